// File: rtl/decoder_pkg.sv
// Shared definitions for the scanning active-low decoder:
// mode encodings and the one-hot active-low helper.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  localparam int   MAX_OUTS    = 256;

  // Position sel cleared in an all-ones word; an out-of-range sel leaves every output released.
  function automatic logic [MAX_OUTS-1:0] onehot_al(input int sel, input int width);
    logic [MAX_OUTS-1:0] r;
    r = ~(MAX_OUTS'(1) << sel);
    if (sel >= width || sel < 0) r = '1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_al_if.sv
// Control and output bundle of the scanning decoder; master drives select/mode/enable,
// slave returns the registered active-low lines, index and wrap pulse.
interface decoder_scan_al_if #(parameter int N = 2);

  localparam int OUTS = 2**N;

  logic            en;
  logic            mode;
  logic [N-1:0]    w;
  logic [OUTS-1:0] y;
  logic [N-1:0]    idx;
  logic            wrap;

  modport master (output en, mode, w, input y, idx, wrap);
  modport slave  (input en, mode, w, output y, idx, wrap);

endinterface

// File: rtl/dwell_timer.sv
// Counts 0..DWELL-1 while run is high; tick marks the last cycle of a dwell period.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = run && (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_scan_al.sv
// Registered N-to-2^N active-low decoder with DIRECT select and SCAN walk over 0..w,
// driving multiplexed loads such as digit commons or LED rows.
module decoder_scan_al
  import decoder_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  decoder_scan_al_if.slave  bus
);

  localparam int OUTS = 2**N;

  logic            mode_q;
  logic [N-1:0]    idx_reg;
  logic [N-1:0]    idx_next;
  logic [OUTS-1:0] y_reg;
  logic [OUTS-1:0] y_next;
  logic            wrap_reg;
  logic            wrap_next;
  logic            scan;
  logic            restart;
  logic            clr;
  logic            run;
  logic            tick;

  assign scan    = (bus.mode == MODE_SCAN);
  // Entering SCAN restarts the walk even while disabled, so it is kept out of run/en gating.
  assign restart = scan && (mode_q == MODE_DIRECT);
  assign clr     = restart || !scan;
  assign run     = bus.en && scan;

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    idx_next  = idx_reg;
    wrap_next = 1'b0;
    y_next    = '1;
    if (restart) begin
      idx_next = '0;
    end else if (!scan) begin
      if (bus.en) idx_next = bus.w;
    end else if (tick) begin
      // Wrapping on idx >= w also recovers when w was lowered below the current position.
      if (idx_reg >= bus.w) begin
        idx_next  = '0;
        wrap_next = 1'b1;
      end else begin
        idx_next = idx_reg + 1'b1;
      end
    end
    if (bus.en) y_next = OUTS'(onehot_al(int'(idx_next), OUTS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_DIRECT;
      idx_reg  <= '0;
      y_reg    <= '1;
      wrap_reg <= 1'b0;
    end else begin
      mode_q   <= bus.mode;
      idx_reg  <= idx_next;
      y_reg    <= y_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bus.y    = y_reg;
  assign bus.idx  = idx_reg;
  assign bus.wrap = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_al.sv
// Randomised and directed bench for decoder_scan_al: a 2-bit/DWELL=4 and a 3-bit/DWELL=1
// instance are compared every cycle against a position/age reference model.
module tb_decoder_scan_al;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_scan_al_if #(.N(2)) bus_a ();
  decoder_scan_al_if #(.N(3)) bus_b ();

  decoder_scan_al #(.N(2), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  decoder_scan_al #(.N(3), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    int pos;
    int age;
    bit mode_q;
    int y;
    bit wrap;
  } model_t;

  model_t ma, mb;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t reset_model(input int outs);
    model_t m;
    m.pos = 0; m.age = 0; m.mode_q = 1'b0; m.y = (1 << outs) - 1; m.wrap = 1'b0;
    return m;
  endfunction

  // Position is held for `dwell` enabled cycles; a finished dwell past w returns to 0 with wrap.
  function automatic model_t model_next(input model_t s, input bit en, input bit mode,
                                        input int w, input int dwell, input int outs);
    model_t n;
    n = s;
    n.wrap = 1'b0;
    n.mode_q = mode;
    if (mode && !s.mode_q) begin
      n.pos = 0;
      n.age = 0;
    end else if (!mode) begin
      n.age = 0;
      if (en) n.pos = w;
    end else if (en) begin
      n.age = s.age + 1;
      if (n.age == dwell) begin
        n.age = 0;
        if (s.pos >= w) begin
          n.pos = 0;
          n.wrap = 1'b1;
        end else begin
          n.pos = s.pos + 1;
        end
      end
    end
    n.y = en ? ((1 << outs) - 1) - (1 << n.pos) : (1 << outs) - 1;
    return n;
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".a.y"},    64'(bus_a.y),    64'(ma.y));
    check_eq({tag, ".a.idx"},  64'(bus_a.idx),  64'(ma.pos));
    check_eq({tag, ".a.wrap"}, 64'(bus_a.wrap), 64'(ma.wrap));
    check_eq({tag, ".a.1hot"}, 64'($countones(~bus_a.y) <= 1), 64'(1));
    check_eq({tag, ".b.y"},    64'(bus_b.y),    64'(mb.y));
    check_eq({tag, ".b.idx"},  64'(bus_b.idx),  64'(mb.pos));
    check_eq({tag, ".b.wrap"}, 64'(bus_b.wrap), 64'(mb.wrap));
    check_eq({tag, ".b.1hot"}, 64'($countones(~bus_b.y) <= 1), 64'(1));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    ma = model_next(ma, bus_a.en, bus_a.mode, int'(bus_a.w), 4, 4);
    mb = model_next(mb, bus_b.en, bus_b.mode, int'(bus_b.w), 1, 8);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int wraps;
    bit found;

    rst = 1'b1;
    bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.w = '0;
    bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.w = '0;
    ma = reset_model(4);
    mb = reset_model(8);
    #12;
    compare_all("reset");
    #1 rst = 1'b0;

    // DIRECT select of position 2, then disable.
    bus_a.en = 1'b1; bus_a.w = 2'd2;
    step("direct");
    check_eq("direct.y_lit", 64'(bus_a.y), 64'(4'b1011));
    check_eq("direct.idx_lit", 64'(bus_a.idx), 64'(2));
    bus_a.en = 1'b0;
    step("direct_off");
    check_eq("direct_off.y_lit", 64'(bus_a.y), 64'(4'b1111));
    $display("phase direct done: compared=%0d", n_cmp);

    // Full scan of 0..3 with DWELL=4; expect two wraps in 32 cycles.
    bus_a.en = 1'b1; bus_a.mode = 1'b1; bus_a.w = 2'd3;
    bus_b.en = 1'b1; bus_b.mode = 1'b1; bus_b.w = 3'd7;
    step("scan_start");
    check_eq("scan_start.y_lit", 64'(bus_a.y), 64'(4'b1110));
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      step("scan");
      if (bus_a.wrap) wraps++;
    end
    check_eq("scan.wrap_count", 64'(wraps), 64'(2));
    $display("phase scan done: compared=%0d", n_cmp);

    // Lower w while at position 3.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("seek3");
      if (ma.pos == 3) found = 1'b1;
    end
    check_eq("seek3.reached", 64'(found), 64'(1));
    bus_a.w = 2'd1;
    for (int i = 0; i < 24; i++) step("shrink");
    $display("phase shrink done: compared=%0d", n_cmp);

    // Enable gap at position 1, dwell count 2.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("seek1");
      if (ma.pos == 1 && ma.age == 2) found = 1'b1;
    end
    check_eq("seek1.reached", 64'(found), 64'(1));
    bus_a.en = 1'b0;
    for (int i = 0; i < 5; i++) step("gap");
    bus_a.en = 1'b1;
    for (int i = 0; i < 12; i++) step("resume");
    $display("phase gap done: compared=%0d", n_cmp);

    // Mode 1->0->1 on the DWELL=1 instance restarts without wrap.
    bus_b.mode = 1'b0;
    step("b_direct");
    bus_b.mode = 1'b1;
    step("b_restart");
    check_eq("b_restart.idx_lit", 64'(bus_b.idx), 64'(0));
    check_eq("b_restart.wrap_lit", 64'(bus_b.wrap), 64'(0));
    for (int i = 0; i < 20; i++) step("b_scan");
    $display("phase restart done: compared=%0d", n_cmp);

    // Asynchronous reset between edges mid-scan.
    #2 rst = 1'b1;
    #1;
    ma = reset_model(4);
    mb = reset_model(8);
    compare_all("async_rst");
    check_eq("async_rst.y_lit", 64'(bus_a.y), 64'(4'b1111));
    #2 rst = 1'b0;
    for (int i = 0; i < 20; i++) step("post_rst");
    $display("phase async reset done: compared=%0d", n_cmp);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus_a.en = ($urandom_range(9) != 0);
      bus_b.en = ($urandom_range(9) != 0);
      if ($urandom_range(30) == 0) bus_a.mode = ~bus_a.mode;
      if ($urandom_range(30) == 0) bus_b.mode = ~bus_b.mode;
      if ($urandom_range(15) == 0) bus_a.w = 2'($urandom);
      if ($urandom_range(15) == 0) bus_b.w = 3'($urandom);
      step("random");
    end
    $display("phase random done: compared=%0d", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
